// File: rtl/rf_operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_of_pkg
// Description : Shared types and constants for the register-file operand
//               fetch stage (D-stage state encoding, zero register, defaults).
// Revision    : 1.0  initial release
// ============================================================================
package rf_of_pkg;

    localparam int DLEN_DEF = 32;
    localparam int ALEN_DEF = 5;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_READ  = 2'd1,
        D_STALL = 2'd2
    } d_state_t;

endpackage
`default_nettype wire

// File: rtl/rf_operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_operand_fetch_if
// Description : Issue, execute, register-file and writeback signals of the
//               operand fetch stage. Names are from the fetch stage's view.
// Revision    : 1.0  initial release
// ============================================================================
interface rf_operand_fetch_if #(
    parameter int DLEN = 32,
    parameter int ALEN = 5
);
    // issue side
    logic            i_valid;
    logic            o_ready;
    logic [ALEN-1:0] i_rs1;
    logic [ALEN-1:0] i_rs2;
    logic [ALEN-1:0] i_rd;
    logic            i_rd_wen;
    // execute side
    logic            o_valid;
    logic            i_ready;
    logic [DLEN-1:0] o_op_a;
    logic [DLEN-1:0] o_op_b;
    logic [ALEN-1:0] o_rd;
    logic            o_rd_wen;
    // register file read ports
    logic [ALEN-1:0] o_raddr_a;
    logic [ALEN-1:0] o_raddr_b;
    logic [DLEN-1:0] i_rdata_a;
    logic [DLEN-1:0] i_rdata_b;
    // writeback bus and register file write port
    logic            i_wb_valid;
    logic [ALEN-1:0] i_wb_addr;
    logic [DLEN-1:0] i_wb_data;
    logic            o_rf_wen;
    logic [ALEN-1:0] o_rf_waddr;
    logic [DLEN-1:0] o_rf_wdata;

    modport slave (
        input  i_valid, i_rs1, i_rs2, i_rd, i_rd_wen, i_ready,
               i_rdata_a, i_rdata_b, i_wb_valid, i_wb_addr, i_wb_data,
        output o_ready, o_valid, o_op_a, o_op_b, o_rd, o_rd_wen,
               o_raddr_a, o_raddr_b, o_rf_wen, o_rf_waddr, o_rf_wdata
    );

    modport master (
        output i_valid, i_rs1, i_rs2, i_rd, i_rd_wen, i_ready,
               i_rdata_a, i_rdata_b, i_wb_valid, i_wb_addr, i_wb_data,
        input  o_ready, o_valid, o_op_a, o_op_b, o_rd, o_rd_wen,
               o_raddr_a, o_raddr_b, o_rf_wen, o_rf_waddr, o_rf_wdata
    );

endinterface
`default_nettype wire

// File: rtl/rf_operand_fetch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Pending-write tracker. One busy bit per register; writeback
//               clears are applied before the lookups and before new sets,
//               so a same-cycle clear+set of one address leaves it busy.
// Revision    : 1.0  initial release
// ============================================================================
module rf_scoreboard
    import rf_of_pkg::*;
#(
    parameter int ALEN  = ALEN_DEF,
    parameter int NREGS = 1 << ALEN
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_clr,
    input  wire logic [ALEN-1:0] i_clr_addr,
    input  wire logic            i_set,
    input  wire logic [ALEN-1:0] i_set_addr,
    input  wire logic [ALEN-1:0] i_look_a,
    input  wire logic [ALEN-1:0] i_look_b,
    input  wire logic [ALEN-1:0] i_look_c,
    output logic                 o_busy_a,
    output logic                 o_busy_b,
    output logic                 o_busy_c
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_wbclr;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_busy_eff;

    // One-hot clear/set masks; register zero can never become busy
    always_comb begin
        w_wbclr = '0;
        w_set   = '0;
        if (i_clr) begin
            w_wbclr[i_clr_addr] = 1'b1;
        end
        if (i_set && (i_set_addr != ALEN'(REG_ZERO))) begin
            w_set[i_set_addr] = 1'b1;
        end
        w_busy_eff = r_busy & ~w_wbclr;
    end

    assign o_busy_a = w_busy_eff[i_look_a];
    assign o_busy_b = w_busy_eff[i_look_b];
    assign o_busy_c = w_busy_eff[i_look_c];

    // Busy bits: clear first, then set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_eff | w_set;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : rf_operand_fetch
// Description : Two-stage operand fetch (D: address hold / hazard check,
//               E: operand register) in front of a 2R/1W register file, with
//               RAW/WAW stall, writeback forwarding and write-port drive.
// Revision    : 1.0  initial release
// ============================================================================
module rf_operand_fetch
    import rf_of_pkg::*;
#(
    parameter int DLEN = DLEN_DEF,
    parameter int ALEN = ALEN_DEF
) (
    input  wire logic           clk,
    input  wire logic           rst,
    rf_operand_fetch_if.slave   bus
);

    d_state_t        r_d_state;
    logic [ALEN-1:0] r_d_rs1;
    logic [ALEN-1:0] r_d_rs2;
    logic [ALEN-1:0] r_d_rd;
    logic            r_d_rd_wen;

    logic            r_e_valid;
    logic [DLEN-1:0] r_e_op_a;
    logic [DLEN-1:0] r_e_op_b;
    logic [ALEN-1:0] r_e_rd;
    logic            r_e_rd_wen;

    logic            w_d_valid;
    logic            w_busy_a;
    logic            w_busy_b;
    logic            w_busy_c;
    logic            w_hazard;
    logic            w_d_adv;
    logic            w_ready;
    logic            w_accept;
    logic [DLEN-1:0] w_fwd_a;
    logic [DLEN-1:0] w_fwd_b;

    assign w_d_valid = (r_d_state != D_IDLE);
    assign w_hazard  = w_d_valid & (w_busy_a | w_busy_b | (r_d_rd_wen & w_busy_c));
    assign w_d_adv   = w_d_valid & ~w_hazard & (~r_e_valid | bus.i_ready);
    assign w_ready   = ~w_d_valid | w_d_adv;
    assign w_accept  = bus.i_valid & bus.o_ready;

    assign bus.o_ready   = w_ready & ~rst;
    assign bus.o_raddr_a = w_d_valid ? r_d_rs1 : bus.i_rs1;
    assign bus.o_raddr_b = w_d_valid ? r_d_rs2 : bus.i_rs2;

    assign bus.o_valid  = r_e_valid;
    assign bus.o_op_a   = r_e_op_a;
    assign bus.o_op_b   = r_e_op_b;
    assign bus.o_rd     = r_e_rd;
    assign bus.o_rd_wen = r_e_rd_wen;

    // Writeback goes straight to the register file; never while in reset
    assign bus.o_rf_wen   = bus.i_wb_valid & (bus.i_wb_addr != ALEN'(REG_ZERO)) & ~rst;
    assign bus.o_rf_waddr = bus.i_wb_addr;
    assign bus.o_rf_wdata = bus.i_wb_data;

    rf_scoreboard #(
        .ALEN (ALEN)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (bus.i_wb_valid),
        .i_clr_addr (bus.i_wb_addr),
        .i_set      (w_d_adv & r_d_rd_wen),
        .i_set_addr (r_d_rd),
        .i_look_a   (r_d_rs1),
        .i_look_b   (r_d_rs2),
        .i_look_c   (r_d_rd),
        .o_busy_a   (w_busy_a),
        .o_busy_b   (w_busy_b),
        .o_busy_c   (w_busy_c)
    );

    // Operand select: x0 reads zero, same-cycle writeback beats the stale RF read
    always_comb begin
        w_fwd_a = bus.i_rdata_a;
        w_fwd_b = bus.i_rdata_b;
        if (r_d_rs1 == ALEN'(REG_ZERO)) begin
            w_fwd_a = '0;
        end else if (bus.i_wb_valid && (bus.i_wb_addr == r_d_rs1)) begin
            w_fwd_a = bus.i_wb_data;
        end
        if (r_d_rs2 == ALEN'(REG_ZERO)) begin
            w_fwd_b = '0;
        end else if (bus.i_wb_valid && (bus.i_wb_addr == r_d_rs2)) begin
            w_fwd_b = bus.i_wb_data;
        end
    end

    // D stage FSM: capture on accept, release on advance, else track hazard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_state  <= D_IDLE;
            r_d_rs1    <= '0;
            r_d_rs2    <= '0;
            r_d_rd     <= '0;
            r_d_rd_wen <= 1'b0;
        end else if (w_accept) begin
            r_d_state  <= D_READ;
            r_d_rs1    <= bus.i_rs1;
            r_d_rs2    <= bus.i_rs2;
            r_d_rd     <= bus.i_rd;
            r_d_rd_wen <= bus.i_rd_wen;
        end else if (w_d_adv) begin
            r_d_state  <= D_IDLE;
        end else if (w_d_valid) begin
            r_d_state  <= w_hazard ? D_STALL : D_READ;
        end
    end

    // E stage: load on advance, drop once execute has taken it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_valid  <= 1'b0;
            r_e_op_a   <= '0;
            r_e_op_b   <= '0;
            r_e_rd     <= '0;
            r_e_rd_wen <= 1'b0;
        end else if (w_d_adv) begin
            r_e_valid  <= 1'b1;
            r_e_op_a   <= w_fwd_a;
            r_e_op_b   <= w_fwd_b;
            r_e_rd     <= r_d_rd;
            r_e_rd_wen <= r_d_rd_wen;
        end else if (bus.i_ready) begin
            r_e_valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_operand_fetch
// Description : Directed bench for rf_operand_fetch with a behavioural
//               register file and an in-order expected-operand queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rf_operand_fetch;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t q[$];
    logic [31:0] rf [32];

    rf_operand_fetch_if #(.DLEN(32), .ALEN(5)) bus ();

    rf_operand_fetch #(.DLEN(32), .ALEN(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: combinational read, write on the clock edge
    assign bus.i_rdata_a = rf[bus.o_raddr_a];
    assign bus.i_rdata_b = rf[bus.o_raddr_b];
    always @(posedge clk) begin
        if (bus.o_rf_wen) rf[bus.o_rf_waddr] <= bus.o_rf_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every execute handshake is matched against the queue head
    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.i_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got rd=%0d with empty queue", bus.o_rd);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("op_a",   bus.o_op_a,           e.a);
                chk("op_b",   bus.o_op_b,           e.b);
                chk("rd",     {27'd0, bus.o_rd},    {27'd0, e.rd});
                chk("rd_wen", {31'd0, bus.o_rd_wen}, {31'd0, e.wen});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.i_wb_valid = 1'b1;
        bus.i_wb_addr  = a;
        bus.i_wb_data  = d;
        tick();
        bus.i_wb_valid = 1'b0;
    endtask

    // Present one instruction until accepted; expected operands go to the queue
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen,
                         input logic [31:0] ea, input logic [31:0] eb);
        bit ok;
        ok = 1'b0;
        bus.i_valid  = 1'b1;
        bus.i_rs1    = rs1;
        bus.i_rs2    = rs2;
        bus.i_rd     = rd;
        bus.i_rd_wen = wen;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            q.push_back('{a: ea, b: eb, rd: rd, wen: wen});
        end else begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got o_ready=0 expected 1 for rd=%0d", rd);
        end
        tick();
        bus.i_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst            = 1'b1;
        bus.i_valid    = 1'b0;
        bus.i_rs1      = '0;
        bus.i_rs2      = '0;
        bus.i_rd       = '0;
        bus.i_rd_wen   = 1'b0;
        bus.i_ready    = 1'b1;
        bus.i_wb_valid = 1'b1;
        bus.i_wb_addr  = 5'd4;
        bus.i_wb_data  = 32'h4444;

        // Reset state, including write-port gating while in reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_o_ready",  {31'd0, bus.o_ready},    32'd0);
        chk("rst_o_valid",  {31'd0, bus.o_valid},    32'd0);
        chk("rst_op_a",     bus.o_op_a,              32'd0);
        chk("rst_op_b",     bus.o_op_b,              32'd0);
        chk("rst_rd",       {27'd0, bus.o_rd},       32'd0);
        chk("rst_rd_wen",   {31'd0, bus.o_rd_wen},   32'd0);
        chk("rst_rf_wen",   {31'd0, bus.o_rf_wen},   32'd0);
        chk("rst_busy",     dut.u_sb.r_busy,         32'd0);
        bus.i_wb_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.o_ready}, 32'd1);
        tick();

        // Preload and basic fetch with N+2 latency
        wb(5'd1, 32'h11);
        wb(5'd2, 32'h22);
        issue(5'd1, 5'd2, 5'd3, 1'b1, 32'h11, 32'h22);
        @(negedge clk);
        chk("lat_n1_valid", {31'd0, bus.o_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("lat_n2_valid", {31'd0, bus.o_valid}, 32'd1);
        chk("busy3_set",    {31'd0, dut.u_sb.r_busy[3]}, 32'd1);
        tick();

        // RAW on x5: stall three cycles, then forward the writeback
        issue(5'd0, 5'd0, 5'd5, 1'b1, 32'd0, 32'd0);
        issue(5'd5, 5'd0, 5'd6, 1'b0, 32'hDEAD, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("raw_stall_ready", {31'd0, bus.o_ready}, 32'd0);
            tick();
        end
        bus.i_wb_valid = 1'b1;
        bus.i_wb_addr  = 5'd5;
        bus.i_wb_data  = 32'hDEAD;
        @(negedge clk);
        chk("raw_release_ready", {31'd0, bus.o_ready}, 32'd1);
        tick();
        bus.i_wb_valid = 1'b0;
        tick();

        // x0: source reads zero, x0 writeback blocked, never busy
        bus.i_wb_valid = 1'b1;
        bus.i_wb_addr  = 5'd0;
        bus.i_wb_data  = 32'hFFFF;
        issue(5'd0, 5'd1, 5'd0, 1'b1, 32'd0, 32'h11);
        @(negedge clk);
        chk("x0_rf_wen", {31'd0, bus.o_rf_wen}, 32'd0);
        tick();
        bus.i_wb_valid = 1'b0;
        @(negedge clk);
        chk("x0_busy", {31'd0, dut.u_sb.r_busy[0]}, 32'd0);
        tick();

        // Backpressure: E holds, D holds, third issue blocked
        bus.i_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd8,  1'b0, 32'h11, 32'h22);
        issue(5'd2, 5'd1, 5'd9,  1'b0, 32'h22, 32'h11);
        bus.i_valid  = 1'b1;
        bus.i_rs1    = 5'd1;
        bus.i_rs2    = 5'd1;
        bus.i_rd     = 5'd10;
        bus.i_rd_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ready", {31'd0, bus.o_ready}, 32'd0);
            chk("bp_valid", {31'd0, bus.o_valid}, 32'd1);
            chk("bp_op_a",  bus.o_op_a,           32'h11);
            chk("bp_rd",    {27'd0, bus.o_rd},    32'd8);
            tick();
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, bus.o_ready}, 32'd1);
        q.push_back('{a: 32'h11, b: 32'h11, rd: 5'd10, wen: 1'b0});
        tick();
        bus.i_valid = 1'b0;
        repeat (3) tick();

        // WAW on x7: retry issues in the writeback cycle, x7 stays busy
        issue(5'd0, 5'd0, 5'd7, 1'b1, 32'd0, 32'd0);
        issue(5'd0, 5'd0, 5'd7, 1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("waw_stall_ready", {31'd0, bus.o_ready}, 32'd0);
            tick();
        end
        bus.i_wb_valid = 1'b1;
        bus.i_wb_addr  = 5'd7;
        bus.i_wb_data  = 32'h77;
        @(negedge clk);
        chk("waw_release_ready", {31'd0, bus.o_ready}, 32'd1);
        tick();
        bus.i_wb_valid = 1'b0;
        @(negedge clk);
        chk("waw_busy7", {31'd0, dut.u_sb.r_busy[7]}, 32'd1);
        chk("waw_valid", {31'd0, bus.o_valid},        32'd1);
        tick();

        // Reset mid-stream with one instruction in E and one in D
        bus.i_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd11, 1'b1, 32'h11, 32'h22);
        issue(5'd1, 5'd2, 5'd12, 1'b1, 32'h11, 32'h22);
        @(negedge clk);
        chk("mid_busy11", {31'd0, dut.u_sb.r_busy[11]}, 32'd1);
        chk("mid_valid",  {31'd0, bus.o_valid},         32'd1);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("mid_rst_busy",  dut.u_sb.r_busy,      32'd0);
        chk("mid_rst_ready", {31'd0, bus.o_ready}, 32'd0);
        q.delete();
        bus.i_ready = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("mid_post_valid", {31'd0, bus.o_valid}, 32'd0);
        tick();

        // Everything issued must have come out exactly once
        for (int i = 0; i < 50 && q.size() > 0; i++) tick();
        chk("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_operand_fetch.md
Name: rf_operand_fetch

Overview:
- Initiator/consumer side of the 2-read/1-write register file.
- Accepts decoded instructions (rs1, rs2, rd) and drives the register file read addresses.
- Tracks pending writes with a scoreboard and stalls on RAW and WAW hazards.
- Forwards same-cycle writeback data, then hands operands to execute through a valid/ready handshake.
- Also drives the register file write port from the writeback bus.

Parameters:
- DLEN, 32, data width of operands and writeback data.
- ALEN, 5, register address width; NREGS = 1<<ALEN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  issue request valid.
- o_ready  out  1  fetch stage can accept an instruction.
- i_rs1  in  ALEN  source register A.
- i_rs2  in  ALEN  source register B.
- i_rd  in  ALEN  destination register.
- i_rd_wen  in  1  instruction writes rd.
- o_valid  out  1  operands valid to execute.
- i_ready  in  1  execute accepts operands.
- o_op_a  out  DLEN  operand A.
- o_op_b  out  DLEN  operand B.
- o_rd  out  ALEN  destination register, passed through.
- o_rd_wen  out  1  destination write enable, passed through.
- o_raddr_a  out  ALEN  to register file read port A.
- o_raddr_b  out  ALEN  to register file read port B.
- i_rdata_a  in  DLEN  register file read data A (combinational read).
- i_rdata_b  in  DLEN  register file read data B (combinational read).
- i_wb_valid  in  1  writeback valid.
- i_wb_addr  in  ALEN  writeback register.
- i_wb_data  in  DLEN  writeback data.
- o_rf_wen  out  1  register file write enable.
- o_rf_waddr  out  ALEN  register file write address.
- o_rf_wdata  out  DLEN  register file write data.

Behaviour:
- Pipeline: D (address hold/check) then E (operand register). Accept in cycle N gives o_valid at cycle N+2 at the earliest. Strictly in order.
- Reset:
  - D FSM goes to D_IDLE.
  - busy[] all 0, o_valid=0, o_op_a/o_op_b/o_rd/o_rd_wen=0.
  - o_ready=0 while rst is high.
- D FSM has three states:
  - D_IDLE: no instruction held.
  - D_READ: instruction held, no hazard, waiting for E to free.
  - D_STALL: instruction held, scoreboard hazard.
  - State is evaluated every cycle from the held instruction.
- D register: captured on i_valid & o_ready.
- o_ready = ~d_valid | d_adv.
- o_raddr_a/b = held rs1/rs2, or i_rs1/i_rs2 in D_IDLE; no X.
- Hazard:
  - busy_eff = busy & ~wbclr, where wbclr is the one-hot of i_wb_addr when i_wb_valid.
  - hazard = busy_eff[rs1] | busy_eff[rs2] | (rd_wen & busy_eff[rd]).
  - Register 0 is never busy.
- Advance: d_adv = d_valid & ~hazard & (~o_valid | i_ready).
- On d_adv:
  - E captures operands.
  - Per operand: if src==0 → 0; else if i_wb_valid & i_wb_addr==src & src!=0 → i_wb_data (forward); else i_rdata.
- Scoreboard:
  - Clear on wbclr first, then set busy[rd] on d_adv & rd_wen & rd!=0.
  - Same address set and cleared in the same cycle → final busy=1.
  - Writeback to a non-busy register: written, no scoreboard error.
- E stage:
  - o_valid holds until i_ready; outputs stay stable while o_valid & ~i_ready.
  - E clears when i_ready & ~d_adv.
- Write port, combinational pass-through:
  - o_rf_wen = i_wb_valid & (i_wb_addr!=0).
  - o_rf_waddr = i_wb_addr, o_rf_wdata = i_wb_data.
- Reset mid-operation drops D and E contents and clears the scoreboard. No writes are issued while rst is high, because o_rf_wen is gated by ~rst.

Decomposition:
- Package rf_of_pkg:
  - d_state_t enum {D_IDLE, D_READ, D_STALL}.
  - REG_ZERO constant.
  - Default DLEN/ALEN localparams.
- Sub-module rf_scoreboard (NREGS busy bits, set/clear ports, three lookup ports with the wbclr mask applied).

Test Plan:
1. Assert rst mid-stream with one instruction in D and one in E → next cycle o_valid=0, busy==0; after release o_ready=1.
2. Preload via wb x1=0x11, x2=0x22; issue rs1=1, rs2=2, rd=3 at cycle N → o_valid at N+2, op_a=0x11, op_b=0x22, busy[3]=1.
3. RAW: issue rd=5 wen, then rs1=5 → D_STALL with o_ready=0 for 3 cycles; wb x5=0xDEAD → forwarded the same cycle, next cycle op_a=0xDEAD.
4. x0: rs1=0 with wb x0=0xFFFF the same cycle → o_rf_wen=0, op_a=0, busy[0] stays 0.
5. Backpressure: i_ready=0 for 4 cycles with 3 issues → E stable, D holds one, o_ready=0; release → outputs in order, none lost or duplicated.
6. WAW: rd=7 pending, new instr rd=7 stalls; wb x7 arrives the same cycle as retry → issues, busy[7]=1 afterward.
